// File: rtl/ocm_nibble_writer.sv
// ocm_nibble_writer
// Write-side companion of the nibble-packed on-chip memory. Coalesces a stream of 4-bit pixel
// writes (20-bit nibble addresses) into 16-bit word writes carrying a per-nibble enable mask.
//
// Two stages:
//   accumulator     : acc_addr_q / acc_data_q / acc_en_q, EMPTY when acc_en_q == 0
//   output register : mem_we / mem_addr / mem_data / mem_nib_en, held until mem_ready
//
// Optional feature: define OCM_WR_TIMEOUT_EN to auto-flush a partial word after
// TIMEOUT_CYCLES idle cycles (8-bit idle counter). Without the macro a partial word is held
// until a word change, a full mask, or an explicit flush.
//
// Simultaneous-event rules:
//   - a word change already sends the held word out this cycle, so a coincident flush does not
//     also push the new nibble; it stays in the accumulator (the caller holds flush until
//     busy falls, so it goes out on a following cycle).
//   - flush acts only if the accumulator was PARTIAL at the start of the cycle; a nibble merged
//     into that word on the same cycle is included in the flushed word.

module ocm_nibble_writer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_addr,
    input  logic [3:0]  in_data,
    input  logic        flush,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_data,
    output logic [3:0]  mem_nib_en,
    output logic        busy
);

    typedef enum logic {
        StEmpty,
        StPartial
    } acc_state_e;

    // Accumulator
    logic [17:0] acc_addr_q, acc_addr_d;
    logic [15:0] acc_data_q, acc_data_d;
    logic [3:0]  acc_en_q,   acc_en_d;
    acc_state_e  acc_state;

    // Handshake / control
    logic        out_free;
    logic        accept;
    logic        flush_req;
    logic        out_load;
    logic [17:0] out_addr;
    logic [15:0] out_data;
    logic [3:0]  out_en;

    // Incoming nibble placed in its lane
    logic [1:0]  in_lane;
    logic [17:0] in_word;
    logic [15:0] lane_mask;
    logic [15:0] lane_data;
    logic [3:0]  lane_en;
    logic [15:0] merged_data;
    logic [3:0]  merged_en;

    // The accumulator state is fully described by its enable mask.
    assign acc_state = (acc_en_q == 4'b0000) ? StEmpty : StPartial;

    // The output register can take a word when it is empty or being drained this cycle.
    assign out_free = !mem_we || mem_ready;
    assign in_ready = out_free;
    assign accept   = in_valid && out_free;
    assign busy     = (acc_state == StPartial) || mem_we;

    assign in_lane     = in_addr[1:0];
    assign in_word     = in_addr[19:2];
    assign lane_mask   = 16'h000F << {in_lane, 2'b00};
    assign lane_data   = {12'h000, in_data} << {in_lane, 2'b00};
    assign lane_en     = 4'b0001 << in_lane;
    // Repeat writes to a lane overwrite it: clear the lane before OR-ing in the new pixel.
    assign merged_data = (acc_data_q & ~lane_mask) | lane_data;
    assign merged_en   = acc_en_q | lane_en;

`ifdef OCM_WR_TIMEOUT_EN
    // Last idle-count value before the auto-flush fires: the flush happens on the edge that
    // closes the TIMEOUT_CYCLES-th idle cycle, so mem_we rises TIMEOUT_CYCLES cycles after
    // the last accept.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] idle_q, idle_d;
    logic       timeout_fire;

    assign timeout_fire = (acc_state == StPartial) && !accept && out_free &&
                          (idle_q >= TimeoutLast);
    assign flush_req    = flush || timeout_fire;

    // Idle counter: restarts on any accept or flush, counts while a partial word sits idle.
    always_comb begin
        idle_d = idle_q;
        if (accept || flush || timeout_fire || (acc_state == StEmpty)) begin
            idle_d = 8'd0;
        end else if (idle_q != 8'hFF) begin
            idle_d = idle_q + 8'd1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= 8'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign flush_req          = flush;
`endif

    // Next accumulator contents and the word (if any) handed to the output register.
    always_comb begin
        acc_addr_d = acc_addr_q;
        acc_data_d = acc_data_q;
        acc_en_d   = acc_en_q;
        out_load   = 1'b0;
        out_addr   = acc_addr_q;
        out_data   = acc_data_q;
        out_en     = acc_en_q;

        if (accept) begin
            unique case (acc_state)
                StEmpty: begin
                    acc_addr_d = in_word;
                    acc_data_d = lane_data;
                    acc_en_d   = lane_en;
                end
                StPartial: begin
                    if (in_word == acc_addr_q) begin
                        if (merged_en == 4'b1111) begin
                            // Word complete: send it straight out and empty the accumulator.
                            out_load   = 1'b1;
                            out_data   = merged_data;
                            out_en     = merged_en;
                            acc_data_d = 16'h0000;
                            acc_en_d   = 4'b0000;
                        end else begin
                            acc_data_d = merged_data;
                            acc_en_d   = merged_en;
                        end
                    end else begin
                        // Word change: held word goes out, new nibble starts a fresh word.
                        out_load   = 1'b1;
                        acc_addr_d = in_word;
                        acc_data_d = lane_data;
                        acc_en_d   = lane_en;
                    end
                end
                default: begin
                end
            endcase
        end

        if (flush_req && (acc_state == StPartial) && out_free && !out_load) begin
            out_load   = 1'b1;
            out_addr   = acc_addr_d;
            out_data   = acc_data_d;
            out_en     = acc_en_d;
            acc_data_d = 16'h0000;
            acc_en_d   = 4'b0000;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_addr_q <= 18'h00000;
            acc_data_q <= 16'h0000;
            acc_en_q   <= 4'b0000;
        end else begin
            acc_addr_q <= acc_addr_d;
            acc_data_q <= acc_data_d;
            acc_en_q   <= acc_en_d;
        end
    end

    // Output register: loads only when free, otherwise holds until mem_ready drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= 18'h00000;
            mem_data   <= 16'h0000;
            mem_nib_en <= 4'b0000;
        end else if (out_load) begin
            mem_we     <= 1'b1;
            mem_addr   <= out_addr;
            mem_data   <= out_data;
            mem_nib_en <= out_en;
        end else if (mem_ready) begin
            mem_we     <= 1'b0;
        end
    end

    // Disabled lanes must read as zero on the memory bus.
    logic [15:0] mem_en_bits;
    assign mem_en_bits = {{4{mem_nib_en[3]}}, {4{mem_nib_en[2]}},
                          {4{mem_nib_en[1]}}, {4{mem_nib_en[0]}}};

    a_disabled_lanes_zero: assert property (
        @(posedge clk) disable iff (!rst_n)
        mem_we |-> ((mem_data & ~mem_en_bits) == 16'h0000)
    );

    // A stalled write must be presented unchanged until the memory takes it.
    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (mem_we && !mem_ready) |=> (mem_we && $stable(mem_addr) && $stable(mem_data) &&
                                    $stable(mem_nib_en))
    );

    // A write always carries at least one enabled nibble.
    a_nonempty_write: assert property (
        @(posedge clk) disable iff (!rst_n)
        mem_we |-> (mem_nib_en != 4'b0000)
    );

endmodule

// File: tb/tb_ocm_nibble_writer.sv
// Bench for ocm_nibble_writer: directed cases for the documented scenarios followed by a
// randomized run, all checked against a lane-array reference model kept in the bench.

module tb_ocm_nibble_writer;

    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_addr = 20'h0;
    logic [3:0]  in_data = 4'h0;
    logic        flush = 1'b0;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic [17:0] mem_addr;
    logic [15:0] mem_data;
    logic [3:0]  mem_nib_en;
    logic        busy;

    ocm_nibble_writer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .flush      (flush),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_nib_en (mem_nib_en),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one pixel slot per lane plus a "pending write" record.
    logic [17:0] m_word;
    logic [3:0]  m_nib [4];
    bit          m_has [4];
    bit          m_we;
    logic [17:0] m_out_addr;
    logic [15:0] m_out_data;
    logic [3:0]  m_out_en;
    int          m_idle;
    bit          m_load;
    logic [17:0] m_la;
    logic [15:0] m_ld;
    logic [3:0]  m_le;

    function automatic bit m_any();
        return m_has[0] || m_has[1] || m_has[2] || m_has[3];
    endfunction

    function automatic bit m_full();
        return m_has[0] && m_has[1] && m_has[2] && m_has[3];
    endfunction

    task automatic m_clear();
        for (int n = 0; n < 4; n++) m_has[n] = 1'b0;
    endtask

    task automatic m_start(input logic [17:0] w, input int l, input logic [3:0] d);
        m_clear();
        m_word   = w;
        m_nib[l] = d;
        m_has[l] = 1'b1;
    endtask

    // Capture the held word as the next memory write.
    task automatic m_snapshot();
        m_load = 1'b1;
        m_la   = m_word;
        m_ld   = 16'h0;
        m_le   = 4'h0;
        for (int n = 0; n < 4; n++) begin
            if (m_has[n]) begin
                m_ld = m_ld + (16'(m_nib[n]) * (16'd1 << (4 * n)));
                m_le = m_le + (4'd1 << n);
            end
        end
    endtask

    task automatic m_reset();
        m_clear();
        m_word = 18'h0;
        m_we   = 1'b0;
        m_idle = 0;
    endtask

    task automatic model_step(input bit v, input logic [19:0] a, input logic [3:0] d,
                              input bit fl, input bit rdy);
        bit          any;
        bit          free;
        bit          acc;
        bit          fl_eff;
        logic [17:0] w;
        int          l;
        any    = m_any();
        free   = !m_we || rdy;
        acc    = v && free;
        fl_eff = fl;
        m_load = 1'b0;
`ifdef OCM_WR_TIMEOUT_EN
        if (any && !acc && free && (m_idle >= int'(TIMEOUT_CYCLES) - 1)) fl_eff = 1'b1;
        if (acc || fl_eff || !any) m_idle = 0;
        else if (m_idle < 255) m_idle++;
`endif
        if (acc) begin
            w = a[19:2];
            l = int'(a[1:0]);
            if (!any) begin
                m_start(w, l, d);
            end else if (w == m_word) begin
                m_nib[l] = d;
                m_has[l] = 1'b1;
                if (m_full()) begin
                    m_snapshot();
                    m_clear();
                end
            end else begin
                m_snapshot();
                m_start(w, l, d);
            end
        end
        if (fl_eff && any && !m_load && free) begin
            m_snapshot();
            m_clear();
        end
        if (m_load) begin
            m_we       = 1'b1;
            m_out_addr = m_la;
            m_out_data = m_ld;
            m_out_en   = m_le;
        end else if (rdy) begin
            m_we = 1'b0;
        end
    endtask

    // One clock cycle: drive at the falling edge, compare, then advance the model.
    task automatic cycle(input bit v, input logic [19:0] a, input logic [3:0] d,
                         input bit fl, input bit rdy);
        @(negedge clk);
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        flush     = fl;
        mem_ready = rdy;
        #1;
        check_eq("in_ready", in_ready, (!m_we || rdy));
        check_eq("mem_we", mem_we, m_we);
        check_eq("busy", busy, (m_any() || m_we));
        if (m_we) begin
            check_eq("mem_addr", mem_addr, m_out_addr);
            check_eq("mem_data", mem_data, m_out_data);
            check_eq("mem_nib_en", mem_nib_en, m_out_en);
        end
        model_step(v, a, d, fl, rdy);
    endtask

    int          first_we;
    bit          r_v;
    bit          r_fl;
    bit          r_rdy;
    logic [17:0] r_word;
    logic [1:0]  r_lane;

    initial begin
        m_reset();
        rst_n = 1'b0;
        #12;
        check_eq("reset_mem_we", mem_we, 0);
        check_eq("reset_mem_addr", mem_addr, 0);
        check_eq("reset_mem_data", mem_data, 0);
        check_eq("reset_nib_en", mem_nib_en, 0);
        check_eq("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four lanes of one word -> single full write one cycle after the 4th accept.
        cycle(1, 20'h00010, 4'h1, 0, 1);
        cycle(1, 20'h00011, 4'h2, 0, 1);
        cycle(1, 20'h00012, 4'h3, 0, 1);
        cycle(1, 20'h00013, 4'h4, 0, 1);
        check_eq("t1_no_early_we", mem_we, 0);
        cycle(0, 20'h0, 4'h0, 0, 1);
        check_eq("t1_we", mem_we, 1);
        check_eq("t1_addr", mem_addr, 18'h00004);
        check_eq("t1_data", mem_data, 16'h4321);
        check_eq("t1_en", mem_nib_en, 4'hF);

        // Word change pushes the partial word out; new nibble stays accumulated.
        cycle(1, 20'h00021, 4'h7, 0, 1);
        cycle(1, 20'h00030, 4'h5, 0, 1);
        cycle(0, 20'h0, 4'h0, 0, 1);
        check_eq("t2_addr", mem_addr, 18'h00008);
        check_eq("t2_data", mem_data, 16'h0070);
        check_eq("t2_en", mem_nib_en, 4'h2);
        check_eq("t2_busy", busy, 1);
        cycle(0, 20'h0, 4'h0, 1, 1);
        cycle(0, 20'h0, 4'h0, 0, 1);
        check_eq("t2_held_addr", mem_addr, 18'h0000C);
        check_eq("t2_held_data", mem_data, 16'h0005);
        check_eq("t2_held_en", mem_nib_en, 4'h1);

        // Repeat lane: last write wins.
        cycle(1, 20'h00016, 4'h9, 0, 1);
        cycle(1, 20'h00016, 4'hA, 0, 1);
        cycle(0, 20'h0, 4'h0, 1, 1);
        cycle(0, 20'h0, 4'h0, 0, 1);
        check_eq("t3_addr", mem_addr, 18'h00005);
        check_eq("t3_data", mem_data, 16'h0A00);
        check_eq("t3_en", mem_nib_en, 4'h4);

        // Back-pressure: stalled write blocks input; releasing it accepts the held input.
        cycle(1, 20'h00050, 4'h6, 0, 1);
        cycle(0, 20'h0, 4'h0, 1, 1);
        cycle(0, 20'h0, 4'h0, 0, 0);
        check_eq("t4_ready_low", in_ready, 0);
        check_eq("t4_we", mem_we, 1);
        cycle(1, 20'h00040, 4'h3, 0, 0);
        check_eq("t4_ready_low2", in_ready, 0);
        cycle(1, 20'h00040, 4'h3, 0, 0);
        check_eq("t4_stable_addr", mem_addr, 18'h00014);
        check_eq("t4_stable_data", mem_data, 16'h0006);
        cycle(1, 20'h00040, 4'h3, 0, 1);
        check_eq("t4_ready_high", in_ready, 1);
        cycle(0, 20'h0, 4'h0, 0, 0);
        check_eq("t4_we_dropped", mem_we, 0);
        check_eq("t4_busy_partial", busy, 1);
        cycle(0, 20'h0, 4'h0, 1, 1);
        cycle(0, 20'h0, 4'h0, 0, 1);

        // Asynchronous reset with a partial word and a pending write.
        cycle(1, 20'h00060, 4'h1, 0, 1);
        cycle(1, 20'h00064, 4'h2, 0, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_eq("t5_pre_we", mem_we, 1);
        check_eq("t5_pre_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_we", mem_we, 0);
        check_eq("t5_rst_addr", mem_addr, 0);
        check_eq("t5_rst_data", mem_data, 0);
        check_eq("t5_rst_en", mem_nib_en, 0);
        check_eq("t5_rst_busy", busy, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 20'h0, 4'h0, 1, 1);
        cycle(0, 20'h0, 4'h0, 0, 1);
        check_eq("t5_no_write", mem_we, 0);

        // Idle partial word: auto-flush only when the timeout feature is built in.
        cycle(1, 20'h00070, 4'h3, 0, 1);
        first_we = -1;
        for (int k = 1; k <= 100; k++) begin
            cycle(0, 20'h0, 4'h0, 0, 1);
            if (mem_we && first_we < 0) first_we = k;
        end
`ifdef OCM_WR_TIMEOUT_EN
        check_eq("t6_timeout_cycle", 32'(first_we), 32'(TIMEOUT_CYCLES + 1));
`else
        check_eq("t6_no_timeout", 32'(first_we), 32'hFFFF_FFFF);
`endif
        cycle(0, 20'h0, 4'h0, 1, 1);
        cycle(0, 20'h0, 4'h0, 0, 1);

        // Randomized traffic over a few hot words plus occasional far addresses.
        for (int i = 0; i < 3000; i++) begin
            r_v    = ($urandom_range(0, 9) < 7);
            r_fl   = ($urandom_range(0, 9) == 0);
            r_rdy  = ($urandom_range(0, 9) < 6);
            r_word = ($urandom_range(0, 7) == 0) ? 18'($urandom) : 18'($urandom_range(0, 3));
            r_lane = 2'($urandom);
            cycle(r_v, {r_word, r_lane}, 4'($urandom), r_fl, r_rdy);
        end

        // Drain and confirm idle.
        for (int i = 0; i < 4; i++) cycle(0, 20'h0, 4'h0, 1, 1);
        cycle(0, 20'h0, 4'h0, 0, 1);
        check_eq("drain_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
